// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control unit:
// FSM state enum, opcodes, ALU/mux select codes and the control bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9
    } state_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control-vector decode for mc_control.
// Ports: state_i (FSM state), mem_ready_i (memory handshake), ctrl_o (strobes).
module mc_outdec
    import mc_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
                // IR load and PC+4 commit only when the fetch completes
                ctrl_o.irwrite = mem_ready_i;
                ctrl_o.pcwrite = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alusrcb = ALUSRCB_IMMSH;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.memwrite = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_REX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_B;
                ctrl_o.aluop   = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alusrca     = 1'b1;
                ctrl_o.alusrcb     = ALUSRCB_B;
                ctrl_o.aluop       = ALUOP_SUB;
                ctrl_o.pcwritecond = 1'b1;
                ctrl_o.pcsource    = PCSRC_ALUOUT;
            end
            S_JMP: begin
                ctrl_o.pcwrite  = 1'b1;
                ctrl_o.pcsource = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic, outputs.
// Ports: clk, rst_n, op, mem_ready in; datapath strobes, aluop1/0, illegal out.
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       aluop1,
    output logic       aluop0,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_REX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REX:    state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign aluop1      = ctrl.aluop[1];
    assign aluop0      = ctrl.aluop[0];
    assign alusrca     = ctrl.alusrca;
    assign alusrcb     = ctrl.alusrcb;
    assign pcsource    = ctrl.pcsource;
    // mem_ready may be high during reset; keep the fetch commit quiet
    assign pcwrite     = ctrl.pcwrite & rst_n;
    assign irwrite     = ctrl.irwrite & rst_n;
    assign pcwritecond = ctrl.pcwritecond;
    assign iord        = ctrl.iord;
    assign memread     = ctrl.memread;
    assign memwrite    = ctrl.memwrite;
    assign regwrite    = ctrl.regwrite;
    assign regdst      = ctrl.regdst;
    assign memtoreg    = ctrl.memtoreg;
    assign illegal     = (state_q == S_DECODE) && !op_legal(op);

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: table of instructions expanded into
// a per-cycle scoreboard of expected control vectors, plus a reset sequence.
module tb_mc_control;

    localparam int P_F  = 0;
    localparam int P_D  = 1;
    localparam int P_MA = 2;
    localparam int P_MR = 3;
    localparam int P_MB = 4;
    localparam int P_MW = 5;
    localparam int P_RX = 6;
    localparam int P_RW = 7;
    localparam int P_BQ = 8;
    localparam int P_J  = 9;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       aluop1, aluop0, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic       pcwrite, pcwritecond, iord, memread, memwrite;
    logic       irwrite, regwrite, regdst, memtoreg, illegal;

    mc_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .mem_ready   (mem_ready),
        .aluop1      (aluop1),
        .aluop0      (aluop0),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsource    (pcsource),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .regwrite    (regwrite),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] act;
    assign act = {aluop1, aluop0, alusrca, alusrcb, pcsource, pcwrite,
                  pcwritecond, iord, memread, memwrite, irwrite,
                  regwrite, regdst, memtoreg, illegal};

    typedef struct {
        logic [5:0]  op;
        int          fw;
        int          mw;
        logic        ill;
        int          len;
        logic [23:0] seq;
    } vec_t;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        int          ph;
        logic [16:0] exp;
    } sb_t;

    sb_t  q[$];
    vec_t tbl[11];
    int   total = 0;
    int   bad   = 0;

    // Expected control vector written straight from the state table
    function automatic logic [16:0] ev(input int ph, input logic r,
                                       input logic ill);
        logic [1:0] aop = 2'b00;
        logic       asa = 1'b0;
        logic [1:0] asb = 2'b00;
        logic [1:0] pcs = 2'b00;
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0;
        logic irw = 0, rw = 0, rd = 0, m2r = 0, il = 0;
        case (ph)
            P_F:  begin mr = 1; asb = 2'b01; irw = r; pw = r; end
            P_D:  begin asb = 2'b11; il = ill; end
            P_MA: begin asa = 1; asb = 2'b10; end
            P_MR: begin mr = 1; iod = 1; end
            P_MB: begin rw = 1; m2r = 1; end
            P_MW: begin mw = 1; iod = 1; end
            P_RX: begin asa = 1; aop = 2'b10; end
            P_RW: begin rw = 1; rd = 1; end
            P_BQ: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            P_J:  begin pw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {aop, asa, asb, pcs, pw, pwc, iod, mr, mw, irw,
                rw, rd, m2r, il};
    endfunction

    task automatic check(input logic [16:0] exp, input string nm);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    task automatic push_ph(input logic [5:0] o, input int ph,
                           input logic r, input logic ill);
        sb_t it;
        it.op  = o;
        it.rdy = r;
        it.ph  = ph;
        it.exp = ev(ph, r, ill);
        q.push_back(it);
    endtask

    task automatic push_instr(input vec_t v);
        int ph, reps;
        for (int i = 0; i < v.len; i++) begin
            ph = int'(v.seq[4*i +: 4]);
            if (ph == P_F)                   reps = v.fw + 1;
            else if (ph == P_MR || ph == P_MW) reps = v.mw + 1;
            else                             reps = 1;
            for (int k = 0; k < reps; k++) begin
                if (ph == P_F || ph == P_MR || ph == P_MW)
                    push_ph(v.op, ph, (k == reps - 1), v.ill);
                else
                    push_ph(v.op, ph, 1'($urandom_range(0, 1)), v.ill);
            end
        end
    endtask

    task automatic drain(input string nm);
        sb_t it;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(negedge clk);
            op        = it.op;
            mem_ready = it.rdy;
            #2;
            check(it.exp, $sformatf("%s_ph%0d", nm, it.ph));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{6'b100011, 0, 0, 1'b0, 5, 24'h43210};
        tbl[1]  = '{6'b101011, 0, 3, 1'b0, 4, 24'h05210};
        tbl[2]  = '{6'b000000, 0, 0, 1'b0, 4, 24'h07610};
        tbl[3]  = '{6'b000100, 0, 0, 1'b0, 3, 24'h00810};
        tbl[4]  = '{6'b000010, 0, 0, 1'b0, 3, 24'h00910};
        tbl[5]  = '{6'b111111, 0, 0, 1'b1, 2, 24'h00010};
        tbl[6]  = '{6'b100011, 2, 2, 1'b0, 5, 24'h43210};
        tbl[7]  = '{6'b101011, 1, 0, 1'b0, 4, 24'h05210};
        tbl[8]  = '{6'b000000, 1, 0, 1'b0, 4, 24'h07610};
        tbl[9]  = '{6'b001000, 0, 0, 1'b1, 2, 24'h00010};
        tbl[10] = '{6'b000100, 2, 0, 1'b0, 3, 24'h00810};

        rst_n     = 1'b0;
        op        = 6'b000000;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check(ev(P_F, 1'b0, 1'b0), "reset_state");
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;

        for (int i = 0; i < 11; i++) begin
            push_instr(tbl[i]);
            drain($sformatf("vec%0d", i));
        end

        // Reset asserted in the middle of an R-type execute
        push_ph(6'b000000, P_F, 1'b1, 1'b0);
        push_ph(6'b000000, P_D, 1'b1, 1'b0);
        drain("rst_pre");
        @(negedge clk);
        mem_ready = 1'b1;
        #2;
        check(ev(P_RX, 1'b1, 1'b0), "rex_before_rst");
        #1 rst_n = 1'b0;
        #1;
        check(ev(P_F, 1'b0, 1'b0), "rst_async");
        @(negedge clk);
        #2;
        check(ev(P_F, 1'b0, 1'b0), "rst_hold");
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #2;
        check(ev(P_F, 1'b1, 1'b0), "rel_fetch");
        push_ph(6'b000000, P_D,  1'b0, 1'b0);
        push_ph(6'b000000, P_RX, 1'b1, 1'b0);
        push_ph(6'b000000, P_RW, 1'b0, 1'b0);
        push_ph(6'b000000, P_F,  1'b0, 1'b0);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
